// File: rtl/isp_loader_if.sv
// Load-stream byte handshake plus the program-memory write bus driven by the loader.
// master = byte source / memory side, slave = loader.
interface isp_loader_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 12
);
  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    isp_write;
  logic [ADDRESS_BITS-1:0] isp_address;
  logic [DATA_WIDTH-1:0]   isp_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, isp_write, isp_address, isp_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, isp_write, isp_address, isp_data
  );
endinterface

// File: rtl/isp_loader.sv
// Boot loader: parses a little-endian word-count header and data words from a byte
// stream, writes them into program memory, then issues a single core start pulse.
//
// state    | meaning
// COUNT_LO | waiting for low byte of the word count
// COUNT_HI | waiting for high byte of the word count
// DATA     | assembling data words, one isp_write per 4 bytes
// START    | one-cycle core start pulse
// DONE     | load finished, waiting for reload
module isp_loader #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDRESS_BITS  = 12,
  parameter logic [19:0] START_ADDRESS = 20'h00000
) (
  input  logic          clock,
  input  logic          reset,
  isp_loader_if.slave   bus,
  input  logic          reload,
  output logic          start,
  output logic [19:0]   prog_address,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    COUNT_LO,
    COUNT_HI,
    DATA,
    START,
    DONE
  } state_t;

  localparam logic [16:0] MEM_WORDS = 17'(1) << ADDRESS_BITS;

  state_t      state;
  logic [7:0]  count_lo_q;
  logic [15:0] word_total;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic        final_pend;
  logic        fire;

  assign fire         = bus.in_valid & bus.in_ready;
  assign prog_address = START_ADDRESS;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= COUNT_LO;
      count_lo_q      <= '0;
      word_total      <= '0;
      word_cnt        <= '0;
      byte_cnt        <= '0;
      word_buf        <= '0;
      final_pend      <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.isp_write   <= 1'b0;
      bus.isp_address <= '0;
      bus.isp_data    <= '0;
      start           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      bus.isp_write <= 1'b0;
      start         <= 1'b0;
      case (state)
        COUNT_LO: begin
          bus.in_ready <= 1'b1;
          if (fire) begin
            count_lo_q <= bus.in_data;
            busy       <= 1'b1;
            state      <= COUNT_HI;
          end
        end
        COUNT_HI: begin
          if (fire) begin
            word_total <= {bus.in_data, count_lo_q};
            if ({1'b0, bus.in_data, count_lo_q} > MEM_WORDS)
              error <= 1'b1;
            if ({bus.in_data, count_lo_q} == 16'd0) begin
              bus.in_ready <= 1'b0;
              start        <= 1'b1;
              state        <= START;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          // Final word: hold one cycle so its write strobe never overlaps start.
          if (final_pend) begin
            final_pend <= 1'b0;
            start      <= 1'b1;
            state      <= START;
          end else if (fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= bus.in_data;
              2'd1: word_buf[15:8]  <= bus.in_data;
              2'd2: word_buf[23:16] <= bus.in_data;
              default: begin
                bus.isp_data    <= DATA_WIDTH'({bus.in_data, word_buf});
                bus.isp_address <= word_cnt[ADDRESS_BITS-1:0];
                bus.isp_write   <= ({1'b0, word_cnt} < MEM_WORDS);
                word_cnt        <= word_cnt + 16'd1;
                if (word_cnt == word_total - 16'd1) begin
                  final_pend   <= 1'b1;
                  bus.in_ready <= 1'b0;
                end
              end
            endcase
          end
        end
        START: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (reload) begin
            done         <= 1'b0;
            error        <= 1'b0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            bus.in_ready <= 1'b1;
            state        <= COUNT_LO;
          end
        end
        default: state <= COUNT_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_isp_loader.sv
// Randomized bench for isp_loader: two instances (12-bit and 2-bit address) share one
// byte stream and are compared against a queue-based model of the expected writes.
module tb_isp_loader;

  logic        clock  = 1'b0;
  logic        reset  = 1'b0;
  logic        reload = 1'b0;
  logic        start_a, start_b, busy_a, busy_b, done_a, done_b, error_a, error_b;
  logic [19:0] prog_a, prog_b;

  localparam logic [19:0] START_B = 20'hABCDE;

  isp_loader_if #(.DATA_WIDTH(32), .ADDRESS_BITS(12)) bus_a ();
  isp_loader_if #(.DATA_WIDTH(32), .ADDRESS_BITS(2))  bus_b ();

  isp_loader #(.DATA_WIDTH(32), .ADDRESS_BITS(12), .START_ADDRESS(20'h00000)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .reload(reload), .start(start_a),
    .prog_address(prog_a), .busy(busy_a), .done(done_a), .error(error_a)
  );

  isp_loader #(.DATA_WIDTH(32), .ADDRESS_BITS(2), .START_ADDRESS(START_B)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .reload(reload), .start(start_b),
    .prog_address(prog_b), .busy(busy_b), .done(done_b), .error(error_b)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: everything observed is recorded here, checks are done by the main process.
  logic [63:0] obs_a[$];
  logic [63:0] obs_b[$];
  int starts_a = 0, starts_b = 0, start_cyc_a = 0, start_cyc_b = 0;
  int overlap_a = 0, overlap_b = 0;

  always @(negedge clock) begin
    if (bus_a.isp_write) obs_a.push_back({32'(bus_a.isp_address), bus_a.isp_data});
    if (bus_b.isp_write) obs_b.push_back({32'(bus_b.isp_address), bus_b.isp_data});
    if (start_a) begin
      starts_a    <= starts_a + 1;
      start_cyc_a <= cyc;
      if (bus_a.isp_write) overlap_a <= overlap_a + 1;
    end
    if (start_b) begin
      starts_b    <= starts_b + 1;
      start_cyc_b <= cyc;
      if (bus_b.isp_write) overlap_b <= overlap_b + 1;
    end
  end

  logic [31:0] words[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    bus_a.in_valid = v;
    bus_b.in_valid = v;
    bus_a.in_data  = d;
    bus_b.in_data  = d;
  endtask

  task automatic check_reset_values();
    check("rst_rdy_a", bus_a.in_ready, 0);
    check("rst_rdy_b", bus_b.in_ready, 0);
    check("rst_wr_a", bus_a.isp_write, 0);
    check("rst_addr_a", bus_a.isp_address, 0);
    check("rst_data_a", bus_a.isp_data, 0);
    check("rst_start_a", start_a, 0);
    check("rst_prog_a", prog_a, 20'h00000);
    check("rst_prog_b", prog_b, START_B);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_err_a", error_a, 0);
    check("rst_err_b", error_b, 0);
  endtask

  // mode 0: continuous valid, 1: valid toggles every cycle, 2: random valid
  task automatic send(input logic [7:0] q[$], input int mode, output int last_acc);
    int   idx = 0;
    int   guard = 0;
    bit   hdr = 0;
    bit   tog = 1;
    logic v;
    logic [15:0] n;
    n = {q[1], q[0]};
    last_acc = 0;
    while (idx < q.size() && guard < 2000) begin
      @(negedge clock);
      guard++;
      if (idx == 2 && !hdr) begin
        hdr = 1;
        check("hdr_err_a", error_a, n > 16'd4096);
        check("hdr_err_b", error_b, n > 16'd4);
      end
      v   = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      drive(v, v ? q[idx] : 8'($urandom()));
      if (v && bus_a.in_ready) begin
        if (idx == q.size() - 1) last_acc = cyc + 1;
        idx++;
      end
    end
    @(negedge clock);
    drive(1'b0, 8'($urandom()));
    if (!hdr && idx >= 2) begin
      check("hdr_err_a", error_a, n > 16'd4096);
      check("hdr_err_b", error_b, n > 16'd4);
    end
    check("send_bytes", idx, q.size());
  endtask

  task automatic run_load(input int n, input int mode);
    logic [7:0]  q[$];
    logic [63:0] ea[$];
    logic [63:0] eb[$];
    logic [15:0] nn;
    int ba, bb, sa, sb, oa, ob, last_acc;
    nn = 16'(n);
    q.push_back(nn[7:0]);
    q.push_back(nn[15:8]);
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++) q.push_back(words[k][8*b +: 8]);
      if (k < 4096) ea.push_back({32'(k % 4096), words[k]});
      if (k < 4)    eb.push_back({32'(k % 4), words[k]});
    end
    ba = obs_a.size(); bb = obs_b.size();
    sa = starts_a; sb = starts_b; oa = overlap_a; ob = overlap_b;
    send(q, mode, last_acc);
    for (int i = 0; i < 40 && !done_a; i++) @(negedge clock);
    check("done_a", done_a, 1);
    check("done_b", done_b, 1);
    check("busy_a", busy_a, 0);
    check("rdy_done_a", bus_a.in_ready, 0);
    check("err_a", error_a, n > 4096);
    check("err_b", error_b, n > 4);
    check("nwr_a", obs_a.size() - ba, ea.size());
    check("nwr_b", obs_b.size() - bb, eb.size());
    foreach (ea[i]) if (ba + i < obs_a.size()) check("wr_a", obs_a[ba + i], ea[i]);
    foreach (eb[i]) if (bb + i < obs_b.size()) check("wr_b", obs_b[bb + i], eb[i]);
    check("nstart_a", starts_a - sa, 1);
    check("nstart_b", starts_b - sb, 1);
    check("overlap_a", overlap_a - oa, 0);
    check("overlap_b", overlap_b - ob, 0);
    check("start_cyc_a", start_cyc_a, last_acc + (n > 0 ? 1 : 0));
    check("prog_a", prog_a, 20'h00000);
    check("prog_b", prog_b, START_B);
  endtask

  task automatic do_reload();
    @(negedge clock) reload = 1'b1;
    @(negedge clock) reload = 1'b0;
    check("rl_done_a", done_a, 0);
    check("rl_err_a", error_a, 0);
    check("rl_err_b", error_b, 0);
    check("rl_rdy_a", bus_a.in_ready, 1);
    check("rl_busy_a", busy_a, 0);
  endtask

  initial begin
    logic [7:0] pq[$];
    int la, nw, st;
    drive(1'b0, 8'h00);
    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b1;
    #1 check("rdy_pre_edge", bus_a.in_ready, 0);
    @(negedge clock);
    check("rdy_post_a", bus_a.in_ready, 1);
    check("rdy_post_b", bus_b.in_ready, 1);
    check("busy_idle", busy_a, 0);

    words = {32'h12345678, 32'hDEADBEEF};
    run_load(2, 0);
    do_reload();
    words = {};
    run_load(0, 0);
    do_reload();
    words = {32'h12345678, 32'hDEADBEEF};
    run_load(2, 1);
    do_reload();
    words = {};
    for (int k = 0; k < 5; k++) words.push_back($urandom());
    run_load(5, 2);
    do_reload();
    words = {32'h11223344};
    run_load(1, 0);

    // Abort a 2-word load after 6 data bytes.
    do_reload();
    pq = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    send(pq, 0, la);
    check("mid_busy", busy_a, 1);
    @(negedge clock) reload = 1'b1;
    @(negedge clock) reload = 1'b0;
    check("rl_ignored_busy", busy_a, 1);
    check("rl_ignored_rdy", bus_a.in_ready, 1);
    nw = obs_a.size();
    st = starts_a;
    #2 reset = 1'b0;
    #1 check_reset_values();
    repeat (3) @(negedge clock);
    check("abort_nwr", obs_a.size(), nw);
    check("abort_nstart", starts_a, st);
    reset = 1'b1;
    words = {$urandom()};
    run_load(1, 0);

    for (int t = 0; t < 25; t++) begin
      int n;
      do_reload();
      n = $urandom_range(0, 9);
      words = {};
      for (int k = 0; k < n; k++) words.push_back($urandom());
      run_load(n, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/isp_loader.md
ISP_LOADER -- requirements
Module: isp_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each isp_data word; the byte-assembly rules below are fixed to 32.
REQ-002 Parameter ADDRESS_BITS, default 12, width of isp_address (word-addressed program memory).
REQ-003 Parameter START_ADDRESS, default 20'h00000, value driven on prog_address with the start pulse.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-006 in_data  input  8  incoming load-stream byte.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; byte transfers when in_valid and in_ready are both high.
REQ-009 reload  input  1  single-cycle request to re-arm after done.
REQ-010 isp_write  output  1  one-cycle program-memory write strobe to the core.
REQ-011 isp_address  output  ADDRESS_BITS  word address for isp_write.
REQ-012 isp_data  output  DATA_WIDTH  word for isp_write.
REQ-013 start  output  1  one-cycle core start pulse.
REQ-014 prog_address  output  20  core start PC, valid with start.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  load completed and start issued.
REQ-017 error  output  1  sticky; header word count exceeded 2^ADDRESS_BITS.

Function
REQ-018 Stream format: count_lo byte, count_hi byte (16-bit word count N, little-endian), then 4*N data bytes, each word little-endian (first byte -> bits 7:0).
REQ-019 States: COUNT_LO, COUNT_HI, DATA, START, DONE; state after reset is COUNT_LO.
REQ-020 in_ready high in COUNT_LO, COUNT_HI, DATA; low in START and DONE.
REQ-021 COUNT_LO -> COUNT_HI on accepted byte; COUNT_HI -> DATA on accepted byte if N != 0, else -> START.
REQ-022 DATA: a 2-bit byte counter selects the byte lane; on the 4th accepted byte the assembled word is registered and isp_write pulses high for exactly the next cycle.
REQ-023 isp_address for word k (0-based) is k modulo 2^ADDRESS_BITS; the word counter increments after each write.
REQ-024 Byte acceptance continues without stall while isp_write is high (one byte per cycle sustained throughput).
REQ-025 When N > 2^ADDRESS_BITS: error sets when COUNT_HI is accepted; words with k >= 2^ADDRESS_BITS are consumed but isp_write is suppressed for them; load otherwise completes normally.
REQ-026 After the final word's byte is accepted the state moves to START; START is entered only after the final isp_write cycle has been issued, never in the same cycle.
REQ-027 START lasts one cycle: start = 1, prog_address = START_ADDRESS; next state DONE.
REQ-028 prog_address holds START_ADDRESS at all times outside reset; start is low in every state except START.
REQ-029 busy = 1 in COUNT_LO (after first byte accepted), COUNT_HI, DATA, START; busy = 0 in COUNT_LO before any byte and in DONE.
REQ-030 done = 1 only in DONE.
REQ-031 DONE: reload high -> COUNT_LO, clearing word counter, byte counter and error; reload ignored in all other states.
REQ-032 in_valid without in_ready has no effect; in_data is don't-care when in_valid low.

Reset
REQ-033 While reset is low: state COUNT_LO, isp_write 0, isp_address 0, isp_data 0, start 0, prog_address START_ADDRESS, busy 0, done 0, error 0, in_ready 0.
REQ-034 Reset assertion mid-load aborts immediately with no further isp_write or start; the next load restarts at count_lo.
REQ-035 in_ready rises on the first rising clock edge after reset deasserts.

Verification
REQ-036 Stream 02 00 | 78 56 34 12 | EF BE AD DE, in_valid continuous -> isp_write at addr 0 data 32'h12345678, addr 1 data 32'hDEADBEEF, then one start pulse, prog_address 0, done 1.
REQ-037 Stream 00 00 -> no isp_write; start pulses the cycle after count_hi is accepted; done 1.
REQ-038 Same two-word stream with in_valid toggled 1/0 every cycle -> identical writes and data; no byte lost or duplicated.
REQ-039 With ADDRESS_BITS=2, N=5 -> error 1 after header; writes only to addresses 0..3; fifth word consumed without isp_write; start still issued.
REQ-040 Reset pulsed low after 6 data bytes of a 2-word load -> outputs at reset values asynchronously; fresh 1-word load then writes address 0 correctly.
REQ-041 In DONE, reload pulse then new 1-word stream 01 00 44 33 22 11 -> error cleared, write addr 0 data 32'h11223344, second start pulse.
